// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage 16-bit pipeline hazard sequencer:
// register address width, sequencer states and ID/EX control-field layout.
package pipe_pkg;

  localparam int REG_AW = 4;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  typedef enum logic [0:0] {
    RUN      = ST_RUN,
    MEM_WAIT = ST_MEM_WAIT
  } state_e;

  // Bit positions of the ID/EX control field; idex_bubble zeroes all of them.
  localparam int IDEX_REGWRITE_BIT = 0;
  localparam int IDEX_MEMTOREG_BIT = 1;
  localparam int IDEX_MEMREAD_BIT  = 2;
  localparam int IDEX_MEMWRITE_BIT = 3;
  localparam int IDEX_BRANCH_BIT   = 4;
  localparam int IDEX_ALUSRC_BIT   = 5;
  localparam int IDEX_REGDST_BIT   = 6;
  localparam int IDEX_ALUOP_LSB    = 7;
  localparam int IDEX_ALUOP_W      = 2;
  localparam int IDEX_CTRL_W       = IDEX_ALUOP_LSB + IDEX_ALUOP_W;

  function automatic logic [IDEX_CTRL_W-1:0] idex_ctrl_apply(
    input logic [IDEX_CTRL_W-1:0] ctrl,
    input logic                   bubble
  );
    return bubble ? '0 : ctrl;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, branch flushes and a data-memory
// wait FSM with timeout, plus stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_regdest,
  input  logic              mem_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              mem_wait,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  import pipe_pkg::*;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  logic [0:0]  state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic        mem_err_q, mem_err_d;

  logic in_wait;
  logic lu;
  logic tmo_hit;
  logic hold;
  logic br_flush;

  assign in_wait = (state_q == ST_MEM_WAIT);

  assign lu = ex_memread & ex_regwrite & (ex_regdest != '0) &
              ((ex_regdest == id_rs) | (id_uses_rt & (ex_regdest == id_rt)));

  // A timed-out access is treated as completed, so it releases the freeze.
  assign tmo_hit  = in_wait & ~mem_ack & (tmo_q == TMO_LAST);
  assign hold     = in_wait ? (~mem_ack & ~tmo_hit) : (mem_req & ~mem_ack);
  assign br_flush = ~hold & mem_branch_taken;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end else if (br_flush) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_wait = rst_n & in_wait;
  assign mem_err  = mem_err_q;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    if (in_wait) begin
      if (mem_ack || tmo_hit) begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
      if (tmo_hit) begin
        mem_err_d = 1'b1;
      end
    end else if (mem_req && !mem_ack) begin
      state_d = ST_MEM_WAIT;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      mem_err_q <= mem_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .inc   (~pc_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .inc   (ifid_flush),
    .count (flush_events)
  );

endmodule
